conv_layer_sched: RTL and testbench
===================================

Name: conv_layer_sched

Overview:
- Top-level layer sequencer for the convolution engine: runs a programmed number of layers back-to-back.
- Per layer: requests a weight/bias load, enables the conv controller until it reports finish, waits a drain window for the last save, then flips the ping-pong activation buffer.
- Sits above conv_ctrl; drives its en_ctrl and consumes its finish; presents a simple start/done interface to the host.

Parameters:
- LAYER_W, 4, width of layer count/index (max 2^LAYER_W-1 layers).
- DRAIN_CYCLES, 2, cycles waited after conv finish before the next layer (save-pipeline flush); legal range 1..255.
- CNT_W, 16, width of per-layer run-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle start request; sampled in IDLE only.
- abort  input  1  abort request; honoured in any state.
- num_layers  input  LAYER_W  layer count; latched on accepted start.
- load_req  output  1  one-cycle pulse requesting a weight/bias load for load_layer.
- load_layer  output  LAYER_W  layer index for the load; valid while load_req=1 and held until the next request.
- load_done  input  1  loader completion pulse; sampled only in WAIT_LOAD.
- en_ctrl  output  1  enable to conv controller; high for the whole RUN state.
- conv_finish  input  1  finish from conv controller; sampled only in RUN.
- layer_idx  output  LAYER_W  current layer index.
- buf_sel  output  1  ping-pong select: 0 = read A/write B, 1 = read B/write A.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when all layers complete.
- aborted  output  1  one-cycle pulse when an abort takes effect.
- last_run_cycles  output  CNT_W  RUN-state cycle count of the most recently finished layer.

Behaviour:
- All outputs are registered. Reset (asynchronous) sets state=IDLE and drives every output to 0, including last_run_cycles and the internal counters.
- States: IDLE, LOAD, WAIT_LOAD, RUN, DRAIN, NEXT, DONE.
- IDLE, start=1:
  - num_layers≠0: latch num_layers; clear layer_idx and buf_sel; go to LOAD.
  - num_layers=0: go to DONE (done pulses 1 cycle later; no load or run occurs).
  - start in any other state is ignored.
- LOAD:
  - load_req=1 and load_layer=layer_idx for exactly one cycle.
  - Go to WAIT_LOAD.
- WAIT_LOAD:
  - Stay until load_done=1, then go to RUN.
  - load_done outside WAIT_LOAD is ignored.
- RUN:
  - en_ctrl=1 on every cycle in RUN; first high cycle is the cycle after load_done is sampled.
  - Run counter cleared on RUN entry; increments each RUN cycle; saturates at all-ones.
  - On conv_finish=1: next cycle en_ctrl=0, last_run_cycles ← counter value including the finish cycle, go to DRAIN.
- DRAIN:
  - Stay exactly DRAIN_CYCLES cycles, then go to NEXT.
- NEXT (1 cycle):
  - buf_sel toggles.
  - If layer_idx == latched num_layers-1: go to DONE, layer_idx unchanged.
  - Otherwise: layer_idx+1, go to LOAD.
- DONE:
  - done=1 for one cycle, go to IDLE.
  - busy stays high during DONE.
  - layer_idx and buf_sel hold their values until the next start.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; en_ctrl and load_req forced 0 that same edge; aborted=1 for one cycle.
  - done is not asserted; last_run_cycles is not updated.
  - abort in IDLE has no effect and no aborted pulse.
- Simultaneous events:
  - abort has priority over conv_finish, load_done and start.
  - conv_finish and load_done arriving in the same cycle: only the input relevant to the current state is acted on.
- Reset asserted mid-operation immediately returns the block to IDLE with all outputs 0.
- Latency for a layer, from LOAD entry to next LOAD entry: 1 + Tload + Trun + DRAIN_CYCLES + 1 cycles.

Test Plan:
- Reset, then start with num_layers=3; loader replies load_done 4 cycles after each load_req; conv_finish after 10 en_ctrl cycles -> load_layer sequence 0,1,2; buf_sel sequence 0,1,0 then 1 at done; en_ctrl high 10 cycles per layer; last_run_cycles=10; single done pulse; busy low after DONE.
- start with num_layers=0 -> no load_req, en_ctrl never high, done pulses 2 cycles after start.
- abort asserted on the 5th RUN cycle of layer 1 (num_layers=4) -> en_ctrl=0 next edge; aborted pulse; state IDLE; done never asserted; last_run_cycles holds the layer-0 value.
- start pulsed during RUN, plus a stray load_done during RUN -> both ignored; sequence identical to an undisturbed run.
- conv_finish held off for 70000 cycles with CNT_W=16 -> last_run_cycles=16'hFFFF.
- Async reset asserted mid-DRAIN (between clock edges) -> all outputs 0 immediately; a following start with num_layers=1 completes normally with buf_sel ending at 1.

Source files
------------

// File: rtl/conv_layer_sched.sv
// Layer sequencer for the convolution engine: load weights, run conv_ctrl, drain
// the save pipeline, flip the ping-pong buffer, repeat for num_layers layers.
module conv_layer_sched #(
  parameter int LAYER_W      = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  output logic               load_req,
  output logic [LAYER_W-1:0] load_layer,
  input  logic               load_done,
  output logic               en_ctrl,
  input  logic               conv_finish,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               buf_sel,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   last_run_cycles,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_LOAD, S_RUN, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  localparam logic [LAYER_W-1:0] ONE_L      = 1;
  localparam logic [CNT_W-1:0]   ONE_C      = 1;
  localparam logic [7:0]         DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [LAYER_W-1:0] r_num_layers;
  logic [7:0]         r_drain_cnt;
  logic [CNT_W-1:0]   r_run_cnt;
  logic [CNT_W-1:0]   w_run_inc;
  logic               w_last_layer;
  logic               w_abort;
  logic               w_accept;

  assign w_abort      = abort && (r_state != S_IDLE);
  assign w_accept     = (r_state == S_IDLE) && start && (num_layers != '0);
  assign w_last_layer = (layer_idx == (r_num_layers - ONE_L));
  // Counter value including the current RUN cycle, held at all-ones once saturated.
  assign w_run_inc    = (r_run_cnt == '1) ? r_run_cnt : (r_run_cnt + ONE_C);
  assign o_dbg_state  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = (num_layers != '0) ? S_LOAD : S_DONE;
      S_LOAD:      w_state_nxt = S_WAIT_LOAD;
      S_WAIT_LOAD: if (load_done) w_state_nxt = S_RUN;
      S_RUN:       if (conv_finish) w_state_nxt = S_DRAIN;
      S_DRAIN:     if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_NEXT;
      S_NEXT:      w_state_nxt = w_last_layer ? S_DONE : S_LOAD;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_num_layers    <= '0;
      r_drain_cnt     <= '0;
      r_run_cnt       <= '0;
      load_req        <= 1'b0;
      load_layer      <= '0;
      en_ctrl         <= 1'b0;
      layer_idx       <= '0;
      buf_sel         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      last_run_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      load_req <= (w_state_nxt == S_LOAD);
      en_ctrl  <= (w_state_nxt == S_RUN);
      busy     <= (w_state_nxt != S_IDLE);
      done     <= (r_state == S_DONE) && !abort;
      aborted  <= w_abort;

      if (w_accept) begin
        r_num_layers <= num_layers;
        layer_idx    <= '0;
        buf_sel      <= 1'b0;
      end

      if (w_state_nxt == S_LOAD)
        load_layer <= (r_state == S_NEXT) ? (layer_idx + ONE_L) : '0;

      if ((r_state == S_NEXT) && !w_abort) begin
        buf_sel <= ~buf_sel;
        if (!w_last_layer) layer_idx <= layer_idx + ONE_L;
      end

      if (r_state == S_RUN) begin
        r_run_cnt <= w_run_inc;
        if (conv_finish && !w_abort) last_run_cycles <= w_run_inc;
      end else begin
        r_run_cnt <= '0;
      end

      r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + 8'd1) : 8'd0;
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with behavioural loader/conv models and
// queue-based scoreboards for load requests and RUN-window lengths.
module tb_conv_layer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  num_layers;
  logic        load_req;
  logic [3:0]  load_layer;
  logic        load_done;
  logic        en_ctrl;
  logic        conv_finish;
  logic [3:0]  layer_idx;
  logic        buf_sel;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] last_run_cycles;
  logic [2:0]  dbg_state;

  logic        ld_model;
  logic        stray_ld;
  int          ld_cnt;
  int          run_len;
  int          conv_cnt;
  int          en_len;
  int          done_cnt;
  int          n_cmp;
  int          n_err;

  logic [4:0]  exp_ld_q[$];
  logic [31:0] exp_run_q[$];

  assign load_done = ld_model | stray_ld;

  conv_layer_sched #(.LAYER_W(4), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_layers(num_layers),
    .load_req(load_req), .load_layer(load_layer), .load_done(load_done),
    .en_ctrl(en_ctrl), .conv_finish(conv_finish), .layer_idx(layer_idx),
    .buf_sel(buf_sel), .busy(busy), .done(done), .aborted(aborted),
    .last_run_cycles(last_run_cycles), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ld(input logic b, input logic [3:0] l);
    exp_ld_q.push_back({b, l});
  endtask

  // Loader: answers each load_req with a load_done pulse 4 cycles later.
  initial begin
    ld_model = 1'b0;
    ld_cnt   = 0;
    forever begin
      @(negedge clk);
      ld_model = 1'b0;
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) ld_model = 1'b1;
      end
      if (load_req) ld_cnt = 4;
    end
  end

  // Conv controller: raises finish during the run_len-th enabled cycle.
  initial begin
    conv_finish = 1'b0;
    conv_cnt    = 0;
    forever begin
      @(negedge clk);
      if (en_ctrl) begin
        conv_cnt++;
        conv_finish = (conv_cnt == run_len);
      end else begin
        conv_cnt    = 0;
        conv_finish = 1'b0;
      end
    end
  end

  // Scoreboard monitor: load requests, RUN-window lengths, done pulses.
  initial begin
    logic [4:0]  e_ld;
    logic [31:0] e_run;
    en_len   = 0;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (load_req) begin
        chk("ld_avail", {31'd0, exp_ld_q.size() != 0}, 32'd1);
        if (exp_ld_q.size() != 0) begin
          e_ld = exp_ld_q.pop_front();
          chk("ld_layer", {28'd0, load_layer}, {28'd0, e_ld[3:0]});
          chk("ld_buf", {31'd0, buf_sel}, {31'd0, e_ld[4]});
        end
      end
      if (en_ctrl) begin
        en_len++;
      end else if (en_len > 0) begin
        chk("run_avail", {31'd0, exp_run_q.size() != 0}, 32'd1);
        if (exp_run_q.size() != 0) begin
          e_run = exp_run_q.pop_front();
          chk("run_len", en_len, e_run);
        end
        en_len = 0;
      end
      if (done) done_cnt++;
    end
  end

  // Start a job and wait (bounded) for done; optionally disturb with start/load_done.
  task automatic run_layers(input logic [3:0] n, input int exp_cyc, input int max_cyc,
                            input int disturb_at);
    int cyc;
    bit got;
    num_layers = n;
    start      = 1'b1;
    cyc        = 0;
    got        = 1'b0;
    while (cyc < max_cyc && !got) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      stray_ld = 1'b0;
      if (cyc == disturb_at) begin
        start      = 1'b1;
        stray_ld   = 1'b1;
        num_layers = 4'd5;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_time", cyc, exp_cyc);
    if (got) chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    stray_ld   = 1'b0;
    num_layers = 4'd0;
    run_len    = 10;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_req", {31'd0, load_req}, 32'd0);
    chk("rst_en_ctrl", {31'd0, en_ctrl}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_last_run", {16'd0, last_run_cycles}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three layers, 4-cycle loads, 10-cycle runs: 3 * 18 cycles + DONE + done pulse.
    push_ld(1'b0, 4'd0); push_ld(1'b1, 4'd1); push_ld(1'b0, 4'd2);
    repeat (3) exp_run_q.push_back(32'd10);
    run_layers(4'd3, 56, 500, 0);
    chk("t1_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t1_layer_idx", {28'd0, layer_idx}, 32'd2);
    chk("t1_last_run", {16'd0, last_run_cycles}, 32'd10);
    @(negedge clk);
    chk("t1_done_single", {31'd0, done}, 32'd0);
    chk("t1_done_cnt", done_cnt, 32'd1);

    // Zero layers: straight to DONE, no load, no run.
    run_layers(4'd0, 2, 50, 0);
    chk("t2_done_cnt", done_cnt, 32'd2);

    // Stray start and load_done during layer-0 RUN must not change anything.
    push_ld(1'b0, 4'd0); push_ld(1'b1, 4'd1);
    repeat (2) exp_run_q.push_back(32'd10);
    run_layers(4'd2, 38, 500, 9);
    chk("t3_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("t3_layer_idx", {28'd0, layer_idx}, 32'd1);
    chk("t3_last_run", {16'd0, last_run_cycles}, 32'd10);
    chk("t3_done_cnt", done_cnt, 32'd3);

    // Abort on the 5th RUN cycle of layer 1 (layer-1 RUN spans cycles 24..33).
    push_ld(1'b0, 4'd0); push_ld(1'b1, 4'd1);
    exp_run_q.push_back(32'd10); exp_run_q.push_back(32'd5);
    @(negedge clk);
    num_layers = 4'd4;
    start      = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 19) run_len = 1000;
    end
    chk("t4_pre_en", {31'd0, en_ctrl}, 32'd1);
    chk("t4_pre_layer", {28'd0, layer_idx}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_en_off", {31'd0, en_ctrl}, 32'd0);
    chk("t4_aborted", {31'd0, aborted}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("t4_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t4_aborted_pulse", {31'd0, aborted}, 32'd0);
    chk("t4_last_run", {16'd0, last_run_cycles}, 32'd10);
    repeat (3) @(negedge clk);
    chk("t4_done_cnt", done_cnt, 32'd3);
    run_len = 10;

    // Abort while idle has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_idle_abort", {31'd0, aborted}, 32'd0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);

    // Run counter saturates when finish is held off past 2^16 cycles.
    push_ld(1'b0, 4'd0);
    exp_run_q.push_back(32'd70000);
    run_len = 70000;
    run_layers(4'd1, 70010, 70100, 0);
    chk("t6_last_run_sat", {16'd0, last_run_cycles}, 32'h0000ffff);
    chk("t6_buf_sel", {31'd0, buf_sel}, 32'd1);
    run_len = 10;
    @(negedge clk);

    // Asynchronous reset in DRAIN (cycles 16..17), then a clean one-layer job.
    push_ld(1'b0, 4'd0);
    exp_run_q.push_back(32'd10);
    num_layers = 4'd2;
    start      = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t7_in_drain", {29'd0, dbg_state}, 32'd4);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_last_run", {16'd0, last_run_cycles}, 32'd0);
    chk("t7_rst_state", {29'd0, dbg_state}, 32'd0);
    chk("t7_rst_buf", {31'd0, buf_sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_ld(1'b0, 4'd0);
    exp_run_q.push_back(32'd10);
    run_layers(4'd1, 20, 200, 0);
    chk("t7_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t7_last_run", {16'd0, last_run_cycles}, 32'd10);

    repeat (2) @(negedge clk);
    chk("ld_q_drained", exp_ld_q.size(), 32'd0);
    chk("run_q_drained", exp_run_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
